fir_filter_mac: RTL

- Parametrised, time-multiplexed FIR filter; successor to the fully parallel 8-bit, 74-tap fir_filter.
- One multiplier-accumulator iterates over all taps per input sample.
- Adds a valid/ready input handshake, an output valid strobe, runtime coefficient loading, round-half-up and saturation with a flag.
- Sits in the sample datapath between the signal source and downstream DSP.

---
 rtl/fir_pkg.sv | 45 ++++
 rtl/fir_hist_buf.sv | 54 +++++
 rtl/fir_filter_mac.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared types and elaboration-time helpers for the time-multiplexed FIR filter.
//   fir_state_e  : controller states (idle / multiply-accumulate / output).
//   clog2        : ceiling log2, minimum 1, used for tap index widths.
//   acc_width    : accumulator width large enough for TAPS full-precision products.
//   sat_max/min  : output clipping limits for a signed sample of the given width.
//   round_bias   : half-LSB constant added before the fractional shift (0 when no fraction).
package fir_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMac  = 2'd1,
        StDone = 2'd2
    } fir_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned coef_w,
                                              input int unsigned taps);
        return data_w + coef_w + clog2(taps);
    endfunction

    function automatic int sat_max(input int unsigned data_w);
        return (1 << (data_w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int unsigned data_w);
        return -(1 << (data_w - 1));
    endfunction

    function automatic longint round_bias(input int unsigned frac_w);
        return (frac_w == 0) ? longint'(0) : (longint'(1) << (frac_w - 1));
    endfunction

endpackage

// File: rtl/fir_hist_buf.sv
// fir_hist_buf: TAPS-deep circular buffer of past input samples.
//   clk, rst : clock and asynchronous active-high reset (clears samples and pointer).
//   i_we     : write i_wdata at the current write pointer.
//   i_adv    : advance the write pointer (wraps TAPS-1 -> 0).
//   i_k      : tap index; o_rdata returns the sample written k samples before the newest.
module fir_hist_buf
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TAPS   = 74
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic signed [DATA_W-1:0] i_wdata,
    input  logic                     i_adv,
    input  logic [clog2(TAPS)-1:0]   i_k,
    output logic signed [DATA_W-1:0] o_rdata
);

    localparam int unsigned KW = clog2(TAPS);

    logic signed [DATA_W-1:0] r_hist [TAPS];
    logic [KW-1:0]            r_ptr;
    logic [KW-1:0]            w_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
            for (int i = 0; i < int'(TAPS); i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            if (i_we) begin
                r_hist[r_ptr] <= i_wdata;
            end
            if (i_adv) begin
                r_ptr <= (r_ptr == KW'(TAPS - 1)) ? '0 : r_ptr + KW'(1);
            end
        end
    end

    // (ptr - k) mod TAPS by compare-and-subtract so non-power-of-two depths wrap correctly.
    always_comb begin
        if (i_k <= r_ptr) begin
            w_idx = r_ptr - i_k;
        end else begin
            w_idx = KW'({1'b0, r_ptr} + (KW + 1)'(TAPS) - {1'b0, i_k});
        end
    end

    assign o_rdata = r_hist[w_idx];

endmodule

// File: rtl/fir_filter_mac.sv
// fir_filter_mac: time-multiplexed FIR filter, one multiply-accumulate per tap per sample.
//   clk, rst             : clock and asynchronous active-high reset.
//   in_valid/in_ready    : sample handshake; a sample is taken only while idle.
//   in_data              : signed input sample.
//   out_valid            : one-cycle strobe; out_data/sat_flag held until the next strobe.
//   out_data, sat_flag   : rounded, clipped result and its clipping indication.
//   coef_we/addr/data    : coefficient write, honoured only while idle.
module fir_filter_mac
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned TAPS   = 74,
    parameter int unsigned FRAC_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     sat_flag,
    input  logic                     coef_we,
    input  logic [clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0] coef_data
);

    localparam int unsigned KW    = clog2(TAPS);
    localparam int unsigned PW    = DATA_W + COEF_W;
    localparam int unsigned ACC_W = acc_width(DATA_W, COEF_W, TAPS);

    // One guard bit above the accumulator so adding the rounding bias cannot wrap.
    localparam logic signed [ACC_W:0] SatMax    = (ACC_W + 1)'(sat_max(DATA_W));
    localparam logic signed [ACC_W:0] SatMin    = (ACC_W + 1)'(sat_min(DATA_W));
    localparam logic signed [ACC_W:0] RoundBias = (ACC_W + 1)'(round_bias(FRAC_W));

    fir_state_e               r_state;
    fir_state_e               w_state_next;
    logic [KW-1:0]            r_k;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [COEF_W-1:0] r_coef [TAPS];
    logic                     r_out_valid;
    logic signed [DATA_W-1:0] r_out_data;
    logic                     r_sat;

    logic                     w_accept;
    logic                     w_mac_last;
    logic signed [DATA_W-1:0] w_hist;
    logic signed [PW-1:0]     w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W:0]    w_sum;
    logic signed [ACC_W:0]    w_shift;
    logic signed [DATA_W-1:0] w_clip;
    logic                     w_sat;

    fir_hist_buf #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) u_hist (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_accept),
        .i_wdata (in_data),
        .i_adv   (w_mac_last),
        .i_k     (r_k),
        .o_rdata (w_hist)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        w_accept     = 1'b0;
        w_mac_last   = 1'b0;
        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = StMac;
                end
            end
            StMac: begin
                if (r_k == KW'(TAPS - 1)) begin
                    w_mac_last   = 1'b1;
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Operands are sign-extended first so the product is exact at full width.
    assign w_prod     = PW'(r_coef[r_k]) * PW'(w_hist);
    assign w_prod_ext = {{(ACC_W - PW){w_prod[PW-1]}}, w_prod};

    assign w_sum   = {r_acc[ACC_W-1], r_acc} + RoundBias;
    assign w_shift = w_sum >>> FRAC_W;

    always_comb begin
        w_clip = w_shift[DATA_W-1:0];
        w_sat  = 1'b0;
        if (w_shift > SatMax) begin
            w_clip = SatMax[DATA_W-1:0];
            w_sat  = 1'b1;
        end else if (w_shift < SatMin) begin
            w_clip = SatMin[DATA_W-1:0];
            w_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k         <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sat       <= 1'b0;
            for (int i = 0; i < int'(TAPS); i++) begin
                r_coef[i] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            // Written at the accept edge, so a same-cycle write is seen by that sample.
            if (r_state == StIdle && coef_we && int'(coef_addr) < int'(TAPS)) begin
                r_coef[coef_addr] <= coef_data;
            end
            if (w_accept) begin
                r_acc <= '0;
                r_k   <= '0;
            end else if (r_state == StMac) begin
                r_acc <= r_acc + w_prod_ext;
                r_k   <= r_k + KW'(1);
            end
            if (r_state == StDone) begin
                r_out_data  <= w_clip;
                r_sat       <= w_sat;
                r_out_valid <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign sat_flag  = r_sat;

endmodule
